stepper_step_gen: RTL and testbench
===================================

// Module: stepper_step_gen
// PURPOSE
//  Parametrised STEP/DIR pulse generator for a stepper driver; successor to the fixed 384-step/200 Hz pulser.
//  Accepts a move command (step count, step period, direction) on a start strobe and emits exactly N step pulses.
//  Guarantees dir-setup time and minimum high-pulse width; supports abort and a busy/done handshake.
//  Sits between the debounced operator controls / sequencer and the driver's MotorPins.
// PARAMETERS
//  STEP_W        16      width of step count and steps_done counter
//  DIV_W         20      width of period (clock cycles per step)
//  PULSE_HI_CYC  100     step_o high time in cycles (>=1)
//  DIR_SETUP_CYC 50      cycles between dir_o update and first step rising edge (>=1)
//  HOLD_EN       1       1: drv_en_n_o stays low after a move (holding torque); 0: released in DONE
//  RAMP_START_DIV 500000 first-step period when ramping (STEPGEN_RAMP_EN only)
//  RAMP_STEP     25000   period change per step when ramping (STEPGEN_RAMP_EN only)
// PORTS
//  Clock50MHz    in  1       system clock, all logic on rising edge
//  Reset_n       in  1       asynchronous active-low reset
//  start_i       in  1       move request, sampled in IDLE only
//  steps_i       in  STEP_W  number of steps to issue
//  period_i      in  DIV_W   target step period in cycles
//  dir_i         in  1       direction for the move
//  abort_i       in  1       stop after the current pulse
//  step_o        out 1       STEP pin
//  dir_o         out 1       DIR pin
//  drv_en_n_o    out 1       driver enable, active low
//  busy_o        out 1       move in progress
//  done_o        out 1       one-cycle strobe at end of move
//  steps_done_o  out STEP_W  steps issued in current/last move
// BEHAVIOUR
//  Reset (async): step_o=0, dir_o=0, drv_en_n_o=1, busy_o=0, done_o=0, steps_done_o=0, state IDLE, abort flag clear.
//  States: IDLE -> SETUP -> HIGH <-> LOW -> DONE -> IDLE.
//  IDLE: start_i=1 and steps_i!=0: latch steps/period/dir, dir_o<=dir_i, drv_en_n_o<=0, busy_o<=1, steps_done_o<=0 -> SETUP.
//   start_i=1 and steps_i==0: done_o=1 next cycle, no step, busy_o stays 0, state stays IDLE.
//  start_i while busy_o=1 ignored; latched command cannot change mid-move.
//  Period clamp: latched period = max(period_i, 2*PULSE_HI_CYC).
//  SETUP: DIR_SETUP_CYC cycles -> HIGH. step_o first rises DIR_SETUP_CYC+1 cycles after start sampled.
//  HIGH: step_o=1 for PULSE_HI_CYC cycles -> LOW; steps_done_o increments by 1 on entry to LOW.
//  LOW: step_o=0 for period-PULSE_HI_CYC cycles; then steps_done_o==target or abort flag -> DONE, else HIGH.
//  DONE: one cycle; done_o=1, busy_o<=0, drv_en_n_o<=~HOLD_EN... i.e. 1 if HOLD_EN=0; -> IDLE.
//  abort_i: sets sticky flag while busy. In SETUP -> DONE next cycle, zero steps. In HIGH/LOW the current pulse
//   completes full high and low time (never truncated). Flag clears in DONE.
//  steps_done_o holds final count until next accepted start. No counter wraps (steps_done <= target <= 2^STEP_W-1).
//  Reset mid-move: outputs forced to reset values immediately, including step_o mid-high.
// CONFIGURATION
//  `STEPGEN_RAMP_EN defined: linear trapezoid ramp. Current period starts at max(RAMP_START_DIV, target).
//   After each completed step (entry to LOW): if remaining <= ramp_cnt: period += RAMP_STEP (cap RAMP_START_DIV),
//   ramp_cnt--; else if period > target: period = max(period-RAMP_STEP, target), ramp_cnt++; else unchanged.
//   New period applies from the next HIGH. Clamp rule still applies.
//  Not defined: constant latched period for every step; RAMP_* parameters unused, no ramp logic synthesised.
// STRUCTURE
//  Package stepper_pkg: state encoding constants (IDLE/SETUP/HIGH/LOW/DONE), default widths STEP_W/DIV_W.
//  Sub-module step_rate_timer: loadable down-counter (DIV_W), load value + start, emits one-cycle expire;
//   reused for SETUP, HIGH and LOW phase timing.
// TESTING (bench params: PULSE_HI_CYC=2, DIR_SETUP_CYC=3, HOLD_EN=0)
//  1 Reset asserted mid-operation -> all outputs at reset values within same cycle, drv_en_n_o=1.
//  2 start steps=3 period=10 dir=1 -> dir_o=1 at cycle 1, step_o rises cycle 4, high 2/low 8, 3 pulses,
//    done_o at cycle 34, steps_done_o=3, drv_en_n_o returns 1.
//  3 start steps=0 -> done_o one cycle later, step_o never rises, busy_o stays 0.
//  4 steps=5 period=10, abort_i pulsed during 2nd high -> 2nd pulse full width + low, done_o, steps_done_o=2.
//  5 period=1 steps=2 -> clamped period 4: step_o high 2, low 2; start during busy ignored.
//  6 RAMP_EN, RAMP_START_DIV=20 RAMP_STEP=5, period=10 steps=6 -> step periods 20,15,10,10,15,20.

Source files
------------

// File: rtl/stepper_pkg.sv
// stepper_pkg: shared state encoding and default widths for the stepper step generator
package stepper_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      DONE
   } state_e;

   localparam int STEP_W_DEF = 16;
   localparam int DIV_W_DEF  = 20;

endpackage

// File: rtl/step_rate_timer.sv
// step_rate_timer: loadable down-counter timing one phase; expire_o marks the phase's final cycle
module step_rate_timer
   import stepper_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             run_q, run_d;

   assign expire_o = run_q && cnt_q == '0;

   // a load of N makes expire_o fire N cycles later, counting the load cycle's successor as the first
   always_comb begin
      cnt_d = load_i ? load_val_i - DIV_W'(1) : (run_q && cnt_q != '0) ? cnt_q - DIV_W'(1) : cnt_q;
      run_d = load_i || (run_q && cnt_q != '0);
   end

   // counter state register
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end

endmodule

// File: rtl/stepper_step_gen.sv
// stepper_step_gen: STEP/DIR pulse generator issuing exactly N timed step pulses per move command
// Optional linear trapezoid ramp is built when STEPGEN_RAMP_EN is defined.
module stepper_step_gen
   import stepper_pkg::*;
#(
   parameter int STEP_W        = STEP_W_DEF,
   parameter int DIV_W         = DIV_W_DEF,
   parameter int PULSE_HI_CYC  = 100,
   parameter int DIR_SETUP_CYC = 50,
   parameter int HOLD_EN       = 1
`ifdef STEPGEN_RAMP_EN
   ,
   parameter int RAMP_START_DIV = 500000,
   parameter int RAMP_STEP      = 25000
`endif
) (
   input  logic              Clock50MHz,
   input  logic              Reset_n,
   input  logic              start_i,
   input  logic [STEP_W-1:0] steps_i,
   input  logic [DIV_W-1:0]  period_i,
   input  logic              dir_i,
   input  logic              abort_i,
   output logic              step_o,
   output logic              dir_o,
   output logic              drv_en_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [STEP_W-1:0] steps_done_o
);

   localparam logic [DIV_W-1:0] HI_LEN    = DIV_W'(PULSE_HI_CYC);
   localparam logic [DIV_W-1:0] MIN_PER   = DIV_W'(2 * PULSE_HI_CYC);
   localparam logic [DIV_W-1:0] SETUP_LEN = DIV_W'(DIR_SETUP_CYC);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] target_q, cnt_q;
   logic [DIV_W-1:0]  period_q, per_w, period_in_w, tmr_val_w;
   logic              dir_q, drv_en_n_q, busy_q, done_q, step_q, abort_q;
   logic              accept_w, zero_w, abort_w, expire_w, tmr_load_w, stepped_w;

   assign accept_w    = state_q == IDLE && start_i && steps_i != '0;
   assign zero_w      = state_q == IDLE && start_i && steps_i == '0;
   assign abort_w     = abort_i || abort_q;
   assign stepped_w   = state_q == HIGH && state_d == LOW;
   assign period_in_w = period_i < MIN_PER ? MIN_PER : period_i;

   assign step_o       = step_q;
   assign dir_o        = dir_q;
   assign drv_en_n_o   = drv_en_n_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign steps_done_o = cnt_q;

   // phase sequencing; an abort only short-cuts SETUP, a running pulse always finishes its low time
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept_w ? SETUP : IDLE;
         SETUP:   state_d = abort_w ? DONE : expire_w ? HIGH : SETUP;
         HIGH:    state_d = expire_w ? LOW : HIGH;
         LOW:     state_d = !expire_w ? LOW : (cnt_q == target_q || abort_w) ? DONE : HIGH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign tmr_load_w = state_d != state_q && (state_d == SETUP || state_d == HIGH || state_d == LOW);
   assign tmr_val_w  = state_d == SETUP ? SETUP_LEN : state_d == HIGH ? HI_LEN : per_w - HI_LEN;

   step_rate_timer #(
      .DIV_W(DIV_W)
   ) u_timer (
      .clk_i     (Clock50MHz),
      .rst_n_i   (Reset_n),
      .load_i    (tmr_load_w),
      .load_val_i(tmr_val_w),
      .expire_o  (expire_w)
   );

   // state, latched command and registered pin/handshake outputs
   always_ff @(posedge Clock50MHz or negedge Reset_n)
      if (!Reset_n) begin
         state_q    <= IDLE;
         target_q   <= '0;
         period_q   <= '0;
         cnt_q      <= '0;
         dir_q      <= 1'b0;
         drv_en_n_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         step_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= state_d == HIGH;
         done_q  <= state_d == DONE || zero_w;
         abort_q <= state_q == DONE ? 1'b0 : abort_q || (busy_q && abort_i);
         if (accept_w) begin
            target_q   <= steps_i;
            period_q   <= period_in_w;
            dir_q      <= dir_i;
            drv_en_n_q <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
         end else begin
            if (stepped_w)
               cnt_q <= cnt_q + STEP_W'(1);
            if (state_q == DONE) begin
               busy_q <= 1'b0;
               if (HOLD_EN == 0)
                  drv_en_n_q <= 1'b1;
            end
         end
      end

`ifdef STEPGEN_RAMP_EN
   logic [DIV_W-1:0]  cur_q, cur_d, top_w, rstart_w, rstep_w;
   logic [STEP_W-1:0] rcnt_q, rcnt_d, rem_w;
   logic [DIV_W:0]    up_w;

   assign rstart_w = DIV_W'(RAMP_START_DIV);
   assign rstep_w  = DIV_W'(RAMP_STEP);
   assign top_w    = rstart_w > period_q ? rstart_w : period_q;
   assign up_w     = {1'b0, cur_q} + {1'b0, rstep_w};
   assign rem_w    = target_q - cnt_q - STEP_W'(1);
   assign per_w    = cur_q;

   // after each step: decelerate once the remaining steps fit the ramp built so far, else accelerate to target
   always_comb begin
      cur_d  = cur_q;
      rcnt_d = rcnt_q;
      if (accept_w) begin
         cur_d  = rstart_w > period_in_w ? rstart_w : period_in_w;
         rcnt_d = '0;
      end else if (stepped_w) begin
         if (rcnt_q != '0 && rem_w <= rcnt_q) begin
            cur_d  = up_w > {1'b0, top_w} ? top_w : up_w[DIV_W-1:0];
            rcnt_d = rcnt_q - STEP_W'(1);
         end else if (cur_q > period_q) begin
            cur_d  = cur_q - period_q > rstep_w ? cur_q - rstep_w : period_q;
            rcnt_d = rcnt_q + STEP_W'(1);
         end
      end
   end

   // ramp period and ramp depth registers
   always_ff @(posedge Clock50MHz or negedge Reset_n)
      if (!Reset_n) begin
         cur_q  <= '0;
         rcnt_q <= '0;
      end else begin
         cur_q  <= cur_d;
         rcnt_q <= rcnt_d;
      end
`else
   assign per_w = period_q;
`endif

endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: directed and randomized moves checked against a step-timeline model
module tb_stepper_step_gen;

   localparam int PH = 2;
   localparam int DS = 3;
`ifdef STEPGEN_RAMP_EN
   localparam int RSD = 20;
   localparam int RST = 5;
`endif

   logic        clk, rst_n, start, dir, abort;
   logic [15:0] steps;
   logic [19:0] period;
   logic        step_o, dir_o, drv_en_n_o, busy_o, done_o;
   logic [15:0] steps_done_o;
   int          checks = 0;
   int          fails = 0;
   int          last_cnt = 0;

   stepper_step_gen #(
      .STEP_W(16), .DIV_W(20), .PULSE_HI_CYC(PH), .DIR_SETUP_CYC(DS), .HOLD_EN(0)
`ifdef STEPGEN_RAMP_EN
      , .RAMP_START_DIV(RSD), .RAMP_STEP(RST)
`endif
   ) dut (
      .Clock50MHz  (clk),
      .Reset_n     (rst_n),
      .start_i     (start),
      .steps_i     (steps),
      .period_i    (period),
      .dir_i       (dir),
      .abort_i     (abort),
      .step_o      (step_o),
      .dir_o       (dir_o),
      .drv_en_n_o  (drv_en_n_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .steps_done_o(steps_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_step"}, step_o, 0);
      chk({tag, "_dir"}, dir_o, 0);
      chk({tag, "_drv_en_n"}, drv_en_n_o, 1);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_steps_done"}, steps_done_o, 0);
   endtask

   // model: pulse k rises at s[k], s[0]=DS+1, s[k+1]=s[k]+per[k]; the move ends per[k] after the last rise
   task automatic run_move(input string tg, input int n, input int p, input int d, input int ab, input int bs);
      int per[$];
      int s[$];
      int tgt, neff, dc, es, ec;
`ifdef STEPGEN_RAMP_EN
      int cur, rc;
`endif
      tgt = p < 2 * PH ? 2 * PH : p;
`ifdef STEPGEN_RAMP_EN
      cur = RSD > tgt ? RSD : tgt;
      rc  = 0;
      for (int k = 1; k <= n; k++) begin
         per.push_back(cur);
         if (n - k <= rc) begin
            cur = cur + RST > RSD ? RSD : cur + RST;
            rc--;
         end else if (cur > tgt) begin
            cur = cur - RST < tgt ? tgt : cur - RST;
            rc++;
         end
      end
`else
      for (int k = 0; k < n; k++) per.push_back(tgt);
`endif
      s.push_back(DS + 1);
      for (int k = 1; k < n; k++) s.push_back(s[k-1] + per[k-1]);
      neff = n;
      dc   = s[n-1] + per[n-1];
      if (ab >= 1 && ab < s[0]) begin
         neff = 0;
         dc   = ab + 1;
      end else if (ab >= 1) begin
         for (int k = 0; k < n; k++)
            if (ab >= s[k] && ab < s[k] + per[k]) begin
               neff = k + 1;
               dc   = s[k] + per[k];
            end
      end
      start  = 1'b1;
      steps  = 16'(n);
      period = 20'(p);
      dir    = d[0];
      tick();
      start = 1'b0;
      for (int t = 1; t <= dc + 1; t++) begin
         es = 0;
         ec = 0;
         for (int k = 0; k < neff; k++) begin
            if (t >= s[k] && t < s[k] + PH) es = 1;
            if (t >= s[k] + PH) ec++;
         end
         chk({tg, "_step"}, step_o, es);
         chk({tg, "_done"}, done_o, t == dc);
         chk({tg, "_steps_done"}, steps_done_o, ec);
         chk({tg, "_dir"}, dir_o, d);
         if (t != dc) begin
            chk({tg, "_busy"}, busy_o, t < dc);
            chk({tg, "_drv_en_n"}, drv_en_n_o, t > dc);
         end
         abort = t == ab;
         start = t == bs && bs < dc;
         if (start) begin
            steps  = 16'($urandom_range(1, 9));
            period = 20'($urandom_range(1, 40));
            dir    = ~dir;
         end
         tick();
      end
      abort    = 1'b0;
      start    = 1'b0;
      last_cnt = neff;
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      abort  = 1'b0;
      steps  = '0;
      period = '0;
      dir    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("por");
      rst_n = 1'b1;
      tick();

      run_move("basic3", 3, 10, 1, 0, 0);

      start  = 1'b1;
      steps  = '0;
      period = 20'd10;
      tick();
      start = 1'b0;
      chk("zero_done", done_o, 1);
      chk("zero_busy", busy_o, 0);
      chk("zero_step", step_o, 0);
      chk("zero_steps_done", steps_done_o, last_cnt);
      chk("zero_drv_en_n", drv_en_n_o, 1);
      tick();
      chk("zero_done_end", done_o, 0);
      chk("zero_busy_end", busy_o, 0);
      chk("zero_step_end", step_o, 0);
      tick();

      run_move("abort_hi2", 5, 10, 0, 15, 0);
      run_move("clamp", 2, 1, 1, 0, 3);
      run_move("abort_setup", 4, 6, 1, 2, 0);
      run_move("abort_lastlow", 2, 10, 1, 13, 0);
`ifdef STEPGEN_RAMP_EN
      run_move("ramp6", 6, 10, 0, 0, 0);
`endif

      start  = 1'b1;
      steps  = 16'd3;
      period = 20'd10;
      dir    = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("midrst_pre_step", step_o, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset("midrst");
      @(posedge clk);
      #1;
      chk_reset("midrst_hold");
      rst_n    = 1'b1;
      last_cnt = 0;
      tick();

      for (int i = 0; i < 10; i++)
         run_move("rand", int'($urandom_range(1, 5)), int'($urandom_range(1, 12)), int'($urandom_range(0, 1)),
                  $urandom_range(0, 1) != 0 ? int'($urandom_range(1, 40)) : 0,
                  $urandom_range(0, 1) != 0 ? int'($urandom_range(1, 30)) : 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
